// File: rtl/hrm_io_bridge_pkg.sv
// Shared definitions for the hrmcpu I/O bridge: FSM state encodings and default RX queue depth.
package hrm_io_bridge_pkg;

   localparam int RX_LGDEPTH_DEF = 2;

   typedef enum logic [1:0] {
      IN_IDLE = 2'd0,
      IN_WR   = 2'd1,
      IN_WAIT = 2'd2
   } in_state_e;

   typedef enum logic [1:0] {
      OUT_IDLE = 2'd0,
      OUT_POP  = 2'd1,
      OUT_SEND = 2'd2
   } out_state_e;

endpackage

// File: rtl/hrm_iob_rxq.sv
// Circular RX byte queue for the hrmcpu I/O bridge; a push on a full queue is dropped unless a pop frees a slot.
module hrm_iob_rxq #(
   parameter int LGDEPTH = 2
) (
   input  logic               clk,
   input  logic               i_rst,
   input  logic               push_i,
   input  logic               pop_i,
   input  logic [7:0]         data_i,
   output logic [7:0]         head_o,
   output logic               empty_o,
   output logic               drop_o,
   output logic [LGDEPTH:0]   level_o
);

   localparam int                 DEPTH   = 1 << LGDEPTH;
   localparam logic [LGDEPTH-1:0] PTR_ONE = LGDEPTH'(1);
   localparam logic [LGDEPTH:0]   LVL_ONE = (LGDEPTH+1)'(1);

   logic [7:0]         mem_q [DEPTH];
   logic [LGDEPTH-1:0] wr_q;
   logic [LGDEPTH-1:0] rd_q;
   logic [LGDEPTH:0]   level_q;
   logic [LGDEPTH:0]   level_d;
   logic               full;
   logic               push_ok;
   logic               pop_ok;

   // Level never exceeds DEPTH, so its MSB alone marks the queue full.
   assign empty_o = (level_q == '0);
   assign full    = level_q[LGDEPTH];
   assign pop_ok  = pop_i & ~empty_o;
   assign push_ok = push_i & (~full | pop_ok);
   assign drop_o  = push_i & ~push_ok;
   assign head_o  = mem_q[rd_q];
   assign level_o = level_q;

   always_comb begin
      level_d = level_q;
      if (push_ok && !pop_ok) begin
         level_d = level_q + LVL_ONE;
      end else if (pop_ok && !push_ok) begin
         level_d = level_q - LVL_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (i_rst) begin
         wr_q    <= '0;
         rd_q    <= '0;
         level_q <= '0;
      end else begin
         if (push_ok) wr_q <= wr_q + PTR_ONE;
         if (pop_ok)  rd_q <= rd_q + PTR_ONE;
         level_q <= level_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_q] <= data_i;
   end

endmodule

// File: rtl/hrm_io_bridge.sv
// Byte-stream front end for hrmcpu: RX queue -> INBOX writer, OUTBOX reader -> valid/ready TX.
// Optional dropped-byte counter enabled by defining HRM_IOB_OVRCNT_EN.
//
// state    | meaning
// IN_IDLE  | wait for queued byte and INBOX space; latch head, pop queue
// IN_WR    | cpu_in_wr strobe
// IN_WAIT  | dead cycle so cpu_in_full reflects the write
// OUT_IDLE | wait for OUTBOX data; latch head into tx_data
// OUT_POP  | cpu_out_rd strobe; raise tx_valid
// OUT_SEND | hold tx_valid/tx_data until tx_ready
module hrm_io_bridge
   import hrm_io_bridge_pkg::*;
#(
   parameter int RX_LGDEPTH = RX_LGDEPTH_DEF
) (
   input  logic                  clk,
   input  logic                  i_rst,
   input  logic                  rx_valid,
   input  logic [7:0]            rx_data,
   output logic [7:0]            cpu_in_data,
   output logic                  cpu_in_wr,
   input  logic                  cpu_in_full,
   input  logic [7:0]            cpu_out_data,
   input  logic                  cpu_out_empty,
   output logic                  cpu_out_rd,
   output logic [7:0]            tx_data,
   output logic                  tx_valid,
   input  logic                  tx_ready,
   output logic [RX_LGDEPTH:0]   rx_level,
   output logic [7:0]            ovr_cnt
);

   in_state_e  in_state_q,  in_state_d;
   out_state_e out_state_q, out_state_d;
   logic [7:0] in_data_q, in_data_d;
   logic       in_wr_q, in_wr_d;
   logic [7:0] tx_data_q, tx_data_d;
   logic       tx_valid_q, tx_valid_d;
   logic       out_rd_q, out_rd_d;
   logic       rxq_pop;
   logic       rxq_empty;
   logic       rx_drop;
   logic [7:0] rxq_head;

   hrm_iob_rxq #(.LGDEPTH(RX_LGDEPTH)) u_rxq (
      .clk     (clk),
      .i_rst   (i_rst),
      .push_i  (rx_valid),
      .pop_i   (rxq_pop),
      .data_i  (rx_data),
      .head_o  (rxq_head),
      .empty_o (rxq_empty),
      .drop_o  (rx_drop),
      .level_o (rx_level)
   );

   always_comb begin
      in_state_d = in_state_q;
      in_data_d  = in_data_q;
      in_wr_d    = 1'b0;
      rxq_pop    = 1'b0;
      case (in_state_q)
         IN_IDLE: begin
            if (!rxq_empty && !cpu_in_full) begin
               in_data_d  = rxq_head;
               rxq_pop    = 1'b1;
               in_wr_d    = 1'b1;
               in_state_d = IN_WR;
            end
         end
         IN_WR:   in_state_d = IN_WAIT;
         IN_WAIT: in_state_d = IN_IDLE;
         default: in_state_d = IN_IDLE;
      endcase
   end

   always_comb begin
      out_state_d = out_state_q;
      tx_data_d   = tx_data_q;
      tx_valid_d  = tx_valid_q;
      out_rd_d    = 1'b0;
      case (out_state_q)
         OUT_IDLE: begin
            if (!cpu_out_empty && !tx_valid_q) begin
               tx_data_d   = cpu_out_data;
               out_rd_d    = 1'b1;
               out_state_d = OUT_POP;
            end
         end
         OUT_POP: begin
            tx_valid_d  = 1'b1;
            out_state_d = OUT_SEND;
         end
         OUT_SEND: begin
            if (tx_ready) begin
               tx_valid_d  = 1'b0;
               out_state_d = OUT_IDLE;
            end
         end
         default: out_state_d = OUT_IDLE;
      endcase
   end

   // Reset drops any byte already popped from the OUTBOX but not yet accepted.
   always_ff @(posedge clk) begin
      if (i_rst) begin
         in_state_q  <= IN_IDLE;
         in_data_q   <= 8'h00;
         in_wr_q     <= 1'b0;
         out_state_q <= OUT_IDLE;
         tx_data_q   <= 8'h00;
         tx_valid_q  <= 1'b0;
         out_rd_q    <= 1'b0;
      end else begin
         in_state_q  <= in_state_d;
         in_data_q   <= in_data_d;
         in_wr_q     <= in_wr_d;
         out_state_q <= out_state_d;
         tx_data_q   <= tx_data_d;
         tx_valid_q  <= tx_valid_d;
         out_rd_q    <= out_rd_d;
      end
   end

   assign cpu_in_data = in_data_q;
   assign cpu_in_wr   = in_wr_q;
   assign cpu_out_rd  = out_rd_q;
   assign tx_data     = tx_data_q;
   assign tx_valid    = tx_valid_q;

`ifdef HRM_IOB_OVRCNT_EN
   logic [7:0] ovr_q, ovr_d;

   always_comb begin
      ovr_d = ovr_q;
      if (rx_drop && ovr_q != 8'hFF) ovr_d = ovr_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (i_rst) ovr_q <= 8'h00;
      else       ovr_q <= ovr_d;
   end

   assign ovr_cnt = ovr_q;
`else
   logic unused_drop;
   assign unused_drop = rx_drop;
   assign ovr_cnt     = 8'h00;
`endif

endmodule
